// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder for the core's load/store port.
// Takes one request at a time, waits WAIT_CYCLES, performs a B/H/W access
// on a word-organised RAM and returns the result over a valid/ready channel.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | ready for a request; also holds one cycle after accept (pend=1)
// WAIT   | counting down programmed wait states
// ACCESS | check latched request, do the single RAM read or write
// RESP   | present response, hold it until rsp_ready
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    logic [1:0]       state;
    logic [3:0]       wait_cnt;
    // Request has been captured but not yet decoded; the check in ACCESS
    // and the wait countdown then start from registered request fields.
    logic             pend;
    logic             we_q;
    logic [31:0]      addr_q;
    logic [2:0]       size_q;
    logic [31:0]      wdata_q;

    logic [31:0]      mem [DEPTH_WORDS];

    logic             in_range;
    logic             size_err;
    logic             align_err;
    logic             acc_err;
    logic [IDX_W-1:0] widx;
    logic [1:0]       off;
    logic [31:0]      cur_word;
    logic [3:0]       byte_en;
    logic [31:0]      st_data;
    logic [31:0]      st_word;
    logic [7:0]       ld_byte;
    logic [15:0]      ld_half;
    logic [31:0]      ld_data;

    // Decode the latched request: error checks, lane enables, load extension.
    always_comb begin
        in_range  = ({2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS));
        widx      = addr_q[IDX_W+1:2];
        off       = addr_q[1:0];
        cur_word  = in_range ? mem[widx] : 32'h0;

        size_err  = 1'b1;
        case (size_q)
            SZ_B, SZ_H, SZ_W: size_err = 1'b0;
            SZ_BU, SZ_HU:     size_err = we_q;
            default:          size_err = 1'b1;
        endcase

        align_err = ((size_q[1:0] == 2'b01) && addr_q[0]) ||
                    ((size_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
        acc_err   = !in_range || size_err || align_err;

        byte_en = 4'b0000;
        st_data = 32'h0;
        case (size_q[1:0])
            2'b00: begin
                byte_en = 4'b0001 << off;
                st_data = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                byte_en = off[1] ? 4'b1100 : 4'b0011;
                st_data = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                st_data = wdata_q;
            end
            default: begin
                byte_en = 4'b0000;
                st_data = 32'h0;
            end
        endcase

        for (int i = 0; i < 4; i++) begin
            st_word[8*i +: 8] = byte_en[i] ? st_data[8*i +: 8] : cur_word[8*i +: 8];
        end

        ld_byte = 8'h0;
        case (off)
            2'd0: ld_byte = cur_word[7:0];
            2'd1: ld_byte = cur_word[15:8];
            2'd2: ld_byte = cur_word[23:16];
            2'd3: ld_byte = cur_word[31:24];
            default: ld_byte = 8'h0;
        endcase
        ld_half = off[1] ? cur_word[31:16] : cur_word[15:0];

        ld_data = 32'h0;
        case (size_q)
            SZ_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            SZ_BU:   ld_data = {24'h0, ld_byte};
            SZ_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            SZ_HU:   ld_data = {16'h0, ld_half};
            SZ_W:    ld_data = cur_word;
            default: ld_data = 32'h0;
        endcase
    end

    // Sequencing FSM, request/response registers and the RAM itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= 4'd0;
            pend      <= 1'b0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            size_q    <= 3'b000;
            wdata_q   <= 32'h0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= 32'h0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (pend) begin
                        pend     <= 1'b0;
                        wait_cnt <= 4'(WAIT_CYCLES);
                        state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
                    end else if (req_valid && req_ready) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        size_q    <= req_size;
                        wdata_q   <= req_wdata;
                        pend      <= 1'b1;
                        req_ready <= 1'b0;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt <= 4'd1) begin
                        wait_cnt <= 4'd0;
                        state    <= S_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_ACCESS: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= acc_err;
                    rsp_rdata <= (acc_err || we_q) ? 32'h0 : ld_data;
                    if (!acc_err && we_q) begin
                        mem[widx] <= st_word;
                    end
                    state <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder. Two instances share
// the request fields: d=0 uses WAIT_CYCLES=2, d=1 uses WAIT_CYCLES=0.
module tb_data_mem_responder;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_rdata0;
    logic [31:0] rsp_rdata1;
    logic [1:0]  rsp_err;

    int checks;
    int errors;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction on instance d; returns data, error and the number of
    // edges from the accepting edge to the first cycle with rsp_valid.
    task automatic do_txn(input int d, input logic we, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        int n;
        n = 0;
        while (!req_ready[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_wdata    = wdata;
        req_valid[d] = 1'b1;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        lat = 0;
        while (lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (rsp_valid[d]) break;
        end
        rdata = (d == 0) ? rsp_rdata0 : rsp_rdata1;
        err   = rsp_err[d];
        rsp_ready[d] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 2'b00 || rsp_valid !== 2'b00 || rsp_err !== 2'b00 ||
            rsp_rdata0 !== 32'h0 || rsp_rdata1 !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b valid=%b err=%b rdata0=%h rdata1=%h, required all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata0, rsp_rdata1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready_rise: req_ready=%b, required 11", req_ready);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_txn(0, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL sw_0x10: rdata=%h err=%b lat=%0d, required 0 0 4", rd, er, lat);
        end
        do_txn(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 4) begin
            errors++;
            $display("FAIL lw_0x10: rdata=%h err=%b lat=%0d, required deadbeef 0 4", rd, er, lat);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic [2:0]  sz  [5]  = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [31:0] ad  [5]  = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h12};
        logic [31:0] exp [5]  = '{32'hDEAD55EF, 32'hFFFFFFDE, 32'h000000DE,
                                  32'hFFFFDEAD, 32'h0000DEAD};
        do_txn(0, 1'b1, 32'h11, 3'b000, 32'hAAAAAA55, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL sb_0x11: err=%b rdata=%h, required 0 0", er, rd);
        end
        for (int i = 0; i < 5; i++) begin
            do_txn(0, 1'b0, ad[i], sz[i], 32'h0, rd, er, lat);
            checks++;
            if (rd !== exp[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL load_lane[%0d] addr=%h size=%b: rdata=%h err=%b, required %h 0",
                         i, ad[i], sz[i], rd, er, exp[i]);
            end
        end
        do_txn(0, 1'b1, 32'h16, 3'b001, 32'h00008001, rd, er, lat);
        do_txn(0, 1'b0, 32'h14, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h80010000 || er !== 1'b0) begin
            errors++;
            $display("FAIL sh_upper_half: rdata=%h err=%b, required 80010000 0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        we_t [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad   [4] = '{32'h12, 32'h11, 32'h10, 32'h10};
        logic [2:0]  sz   [4] = '{3'b010, 3'b001, 3'b011, 3'b100};
        for (int i = 0; i < 4; i++) begin
            do_txn(0, we_t[i], ad[i], sz[i], 32'h00001234, rd, er, lat);
            checks++;
            if (er !== 1'b1 || rd !== 32'h0) begin
                errors++;
                $display("FAIL illegal[%0d] addr=%h size=%b we=%b: err=%b rdata=%h, required 1 0",
                         i, ad[i], sz[i], we_t[i], er, rd);
            end
        end
        do_txn(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
            errors++;
            $display("FAIL word_unchanged: rdata=%h err=%b, required dead55ef 0", rd, er);
        end
    endtask

    task automatic test_range();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_txn(0, 1'b0, 32'h400, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL lw_0x400: err=%b rdata=%h, required 1 0", er, rd);
        end
        do_txn(0, 1'b0, 32'h3FC, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL lw_0x3fc: err=%b rdata=%h, required 0 0", er, rd);
        end
        do_txn(0, 1'b1, 32'h80000010, 3'b010, 32'h11111111, rd, er, lat);
        checks++;
        if (er !== 1'b1) begin
            errors++;
            $display("FAIL sw_alias: err=%b, required 1", er);
        end
        do_txn(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD55EF) begin
            errors++;
            $display("FAIL no_alias_write: rdata=%h, required dead55ef", rd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        req_we = 1'b0; req_addr = 32'h10; req_size = 3'b010; req_wdata = 32'h0;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        n = 0;
        while (!rsp_valid[0] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!rsp_valid[0]) begin
            errors++;
            $display("FAIL bp_response: rsp_valid=%b, required 1", rsp_valid[0]);
        end
        req_we = 1'b1; req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            req_valid[0] = i[0];
            @(posedge clk); #1;
            checks++;
            if (rsp_valid[0] !== 1'b1 || rsp_rdata0 !== 32'hDEAD55EF ||
                rsp_err[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b ready=%b, required 1 dead55ef 0 0",
                         i, rsp_valid[0], rsp_rdata0, rsp_err[0], req_ready[0]);
            end
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1;
        rsp_ready[0] = 1'b0;
        checks++;
        if (rsp_valid[0] !== 1'b0 || rsp_rdata0 !== 32'h0 || req_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: valid=%b rdata=%h ready=%b, required 0 0 1",
                     rsp_valid[0], rsp_rdata0, req_ready[0]);
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[0]) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL bp_extra_resp: extra valid cycles=%0d, required 0", n);
        end
        do_txn(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD55EF) begin
            errors++;
            $display("FAIL bp_store_ignored: rdata=%h, required dead55ef", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          n;
        req_we = 1'b1; req_addr = 32'h20; req_size = 3'b010; req_wdata = 32'h12345678;
        req_valid[0] = 1'b1;
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_state: valid=%b ready=%b, required 0 0", rsp_valid[0], req_ready[0]);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 2'b11) begin
            errors++;
            $display("FAIL mid_reset_ready: req_ready=%b, required 11", req_ready);
        end
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (rsp_valid[0]) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL mid_reset_no_resp: valid cycles=%0d, required 0", n);
        end
        do_txn(0, 1'b0, 32'h20, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_lw_0x20: rdata=%h err=%b, required 0 0", rd, er);
        end
        do_txn(0, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_ram_clear: rdata=%h, required 0", rd);
        end
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd;
        logic        er;
        int          lat;
        do_txn(1, 1'b1, 32'h10, 3'b010, 32'hDEADBEEF, rd, er, lat);
        checks++;
        if (er !== 1'b0 || lat !== 2) begin
            errors++;
            $display("FAIL zw_sw: err=%b lat=%0d, required 0 2", er, lat);
        end
        do_txn(1, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEADBEEF || lat !== 2) begin
            errors++;
            $display("FAIL zw_lw: rdata=%h lat=%0d, required deadbeef 2", rd, lat);
        end
        do_txn(1, 1'b1, 32'h11, 3'b000, 32'h00000055, rd, er, lat);
        do_txn(1, 1'b0, 32'h10, 3'b010, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hDEAD55EF) begin
            errors++;
            $display("FAIL zw_byte_merge: rdata=%h, required dead55ef", rd);
        end
        do_txn(1, 1'b0, 32'h13, 3'b000, 32'h0, rd, er, lat);
        checks++;
        if (rd !== 32'hFFFFFFDE || lat !== 2) begin
            errors++;
            $display("FAIL zw_lb: rdata=%h lat=%0d, required ffffffde 2", rd, lat);
        end
        do_txn(1, 1'b0, 32'h13, 3'b101, 32'h0, rd, er, lat);
        checks++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            errors++;
            $display("FAIL zw_lhu_misaligned: err=%b rdata=%h, required 1 0", er, rd);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b00;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_size  = 3'b000;
        req_wdata = 32'h0;
        test_reset();
        test_word();
        test_byte_lanes();
        test_errors();
        test_range();
        test_backpressure();
        test_reset_mid();
        test_zero_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
